// File: rtl/oc_line_rx_if.sv
// Consumer-side handshake bundle of the open-collector line receiver:
// payload, valid/ready and the two one-cycle status pulses.
interface oc_line_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/oc_line_rx.sv
// Start/data/stop receiver for the shared pulled-up line; acknowledges every
// accepted frame by enabling an external open-collector pull-down for one bit time.
module oc_line_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          line,
    oc_line_rx_if.master  rx,
    output logic          ack_en,
    output logic          busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_STOP     = 3'd3,
        ST_ACK_WAIT = 3'd4,
        ST_ACK      = 3'd5,
        ST_BREAK    = 3'd6
    } state_t;

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 s_line;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;

    assign s_line       = sync2_q;
    assign rx.rx_data   = data_q;
    assign rx.rx_valid  = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.overrun   = ovr_q;
    assign ack_en       = ack_q;
    assign busy         = busy_q;

    // Two-flop synchronizer; resets to the idle (released) level.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= line;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            shift_q <= {DATA_BITS{1'b0}};
            data_q  <= {DATA_BITS{1'b0}};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // Consumption is evaluated first so a same-edge load can override it.
        if (valid_q && rx.rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                idx_d = {IDX_W{1'b0}};
                if (!s_line) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (s_line) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {s_line, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (!s_line) begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end else if (!valid_q || rx.rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_ACK_WAIT;
                    end else begin
                        ovr_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_ACK_WAIT: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_ACK_WAIT;
                end
            end
            ST_ACK: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_BREAK;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_BREAK: begin
                // Our own acknowledge also holds the line low; wait for release.
                cnt_d = {CNT_W{1'b0}};
                if (s_line) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                idx_d   = {IDX_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase

        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end
endmodule

// File: tb/tb_oc_line_rx.sv
// Directed bench: pulled-up line with a transmitter pull-down and the
// receiver's acknowledge pull-down, edge-accurate checks against hand timing.
module tb_oc_line_rx;
    localparam int N = 16;

    logic clk    = 1'b0;
    logic clrn   = 1'b1;
    logic tx_low = 1'b0;
    logic ack_en;
    logic busy;
    tri1  line;

    int n_tests = 0;
    int n_fail  = 0;

    oc_line_rx_if #(.DATA_BITS(8)) rif ();

    bufif1 u_tx_drv  (line, 1'b0, tx_low);
    bufif1 u_ack_drv (line, 1'b0, ack_en);

    oc_line_rx #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .line   (line),
        .rx     (rif),
        .ack_en (ack_en),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Observations recorded by run_frame, edge numbers relative to e0.
    logic       rec_v153, rec_v154;
    logic [7:0] rec_d154;
    int         rec_ack_cnt, rec_ack_first, rec_ack_last;
    int         rec_ferr_cnt, rec_ferr_edge, rec_ovr_cnt, rec_ovr_edge;
    logic       busy_hist [0:255];
    logic       rst_busy_pre, rst_ack_pre;
    logic       rst_valid, rst_ack, rst_busy, rst_ferr, rst_ovr, rst_line;
    logic [7:0] rst_data;

    function automatic logic tx_bit_low(input int e, input logic [7:0] d, input logic stop_b,
                                        input int tail, input int glitch);
        int b;
        if (glitch > 0) return (e < glitch);
        b = e / N;
        if (b == 0) return 1'b1;
        if (b <= 8) return ~d[b-1];
        if (b == 9) return ~stop_b;
        if (!stop_b && (e < 10 * N + tail)) return 1'b1;
        return 1'b0;
    endfunction

    // Called #1 after a rising edge; iteration e drives the level captured at edge e.
    task automatic run_frame(input logic [7:0] d, input logic stop_b, input int tail,
                             input int glitch, input int ncyc, input int rdy_edge,
                             input logic rdy_dflt, input int rst_edge);
        rec_v153 = 1'bx; rec_v154 = 1'bx; rec_d154 = 8'hxx;
        rec_ack_cnt = 0; rec_ack_first = -1; rec_ack_last = -1;
        rec_ferr_cnt = 0; rec_ferr_edge = -1; rec_ovr_cnt = 0; rec_ovr_edge = -1;
        for (int i = 0; i < 256; i++) busy_hist[i] = 1'bx;
        for (int e = 0; e < ncyc; e++) begin
            tx_low = tx_bit_low(e, d, stop_b, tail, glitch);
            rif.rx_ready = (e == rdy_edge) ? 1'b1 : rdy_dflt;
            @(posedge clk);
            #1;
            busy_hist[e] = busy;
            if (e == 153) rec_v153 = rif.rx_valid;
            if (e == 154) begin
                rec_v154 = rif.rx_valid;
                rec_d154 = rif.rx_data;
            end
            if (ack_en) begin
                if (rec_ack_cnt == 0) rec_ack_first = e;
                rec_ack_last = e;
                rec_ack_cnt++;
            end
            if (rif.frame_err) begin
                rec_ferr_cnt++;
                rec_ferr_edge = e;
            end
            if (rif.overrun) begin
                rec_ovr_cnt++;
                rec_ovr_edge = e;
            end
            if (e == rst_edge) begin
                rst_busy_pre = busy;
                rst_ack_pre  = ack_en;
                clrn   = 1'b0;
                tx_low = 1'b0;
                #2;
                rst_valid = rif.rx_valid;
                rst_data  = rif.rx_data;
                rst_ack   = ack_en;
                rst_busy  = busy;
                rst_ferr  = rif.frame_err;
                rst_ovr   = rif.overrun;
                rst_line  = line;
                @(posedge clk);
                #1;
                clrn = 1'b1;
                break;
            end
        end
        tx_low = 1'b0;
        rif.rx_ready = rdy_dflt;
    endtask

    task automatic idle(input int n);
        tx_low = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rif.rx_ready = 1'b0;
        #2 clrn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (rif.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rif.rx_valid); end
        n_tests++; if (rif.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rif.rx_data); end
        n_tests++; if (ack_en !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", ack_en); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if ({rif.frame_err, rif.overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {rif.frame_err, rif.overrun}); end
        n_tests++; if (line !== 1'b1) begin n_fail++; $display("FAIL reset_line got %b want 1", line); end
        clrn = 1'b1;
        idle(4);
    endtask

    task automatic test_basic_a5;
        run_frame(8'hA5, 1'b1, 0, 0, 190, -1, 1'b1, -1);
        n_tests++; if (busy_hist[1] !== 1'b0) begin n_fail++; $display("FAIL a5_busy_e1 got %b want 0", busy_hist[1]); end
        n_tests++; if (busy_hist[2] !== 1'b1) begin n_fail++; $display("FAIL a5_busy_e2 got %b want 1", busy_hist[2]); end
        n_tests++; if (rec_v153 !== 1'b0) begin n_fail++; $display("FAIL a5_valid_e153 got %b want 0", rec_v153); end
        n_tests++; if (rec_v154 !== 1'b1) begin n_fail++; $display("FAIL a5_valid_e154 got %b want 1", rec_v154); end
        n_tests++; if (rec_d154 !== 8'hA5) begin n_fail++; $display("FAIL a5_data got %h want a5", rec_d154); end
        n_tests++; if (rec_ack_cnt !== 16) begin n_fail++; $display("FAIL a5_ack_len got %0d want 16", rec_ack_cnt); end
        n_tests++; if (rec_ack_first !== 162) begin n_fail++; $display("FAIL a5_ack_first got %0d want 162", rec_ack_first); end
        n_tests++; if (rec_ack_last !== 177) begin n_fail++; $display("FAIL a5_ack_last got %0d want 177", rec_ack_last); end
        n_tests++; if (rec_ferr_cnt + rec_ovr_cnt !== 0) begin n_fail++; $display("FAIL a5_no_err got %0d want 0", rec_ferr_cnt + rec_ovr_cnt); end
        n_tests++; if ({busy_hist[180], busy_hist[181]} !== 2'b10) begin n_fail++; $display("FAIL a5_busy_exit got %b want 10", {busy_hist[180], busy_hist[181]}); end
        idle(8);
    endtask

    task automatic test_glitch;
        run_frame(8'h00, 1'b1, 0, 3, 30, -1, 1'b1, -1);
        n_tests++; if (busy_hist[2] !== 1'b1) begin n_fail++; $display("FAIL glitch_start got %b want 1", busy_hist[2]); end
        n_tests++; if ({busy_hist[9], busy_hist[10]} !== 2'b10) begin n_fail++; $display("FAIL glitch_abort got %b want 10", {busy_hist[9], busy_hist[10]}); end
        n_tests++; if (rec_ack_cnt + rec_ferr_cnt + rec_ovr_cnt !== 0) begin n_fail++; $display("FAIL glitch_quiet got %0d want 0", rec_ack_cnt + rec_ferr_cnt + rec_ovr_cnt); end
        n_tests++; if (rif.rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid got %b want 0", rif.rx_valid); end
        idle(4);
    endtask

    task automatic test_frame_err;
        run_frame(8'h3C, 1'b0, 40, 0, 210, -1, 1'b1, -1);
        n_tests++; if (rec_ferr_cnt !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", rec_ferr_cnt); end
        n_tests++; if (rec_ferr_edge !== 154) begin n_fail++; $display("FAIL ferr_edge got %0d want 154", rec_ferr_edge); end
        n_tests++; if (rec_ack_cnt !== 0) begin n_fail++; $display("FAIL ferr_no_ack got %0d want 0", rec_ack_cnt); end
        n_tests++; if (rec_v154 !== 1'b0) begin n_fail++; $display("FAIL ferr_valid got %b want 0", rec_v154); end
        n_tests++; if ({busy_hist[201], busy_hist[202]} !== 2'b10) begin n_fail++; $display("FAIL ferr_break_exit got %b want 10", {busy_hist[201], busy_hist[202]}); end
        idle(8);
    endtask

    task automatic test_overrun;
        run_frame(8'h11, 1'b1, 0, 0, 190, -1, 1'b0, -1);
        n_tests++; if ({rec_v154, rec_d154} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovr_first got %b/%h want 1/11", rec_v154, rec_d154); end
        idle(8);
        run_frame(8'h22, 1'b1, 0, 0, 190, -1, 1'b0, -1);
        n_tests++; if ({rec_v153, rec_v154} !== 2'b11) begin n_fail++; $display("FAIL ovr_valid got %b want 11", {rec_v153, rec_v154}); end
        n_tests++; if (rec_d154 !== 8'h11) begin n_fail++; $display("FAIL ovr_data got %h want 11", rec_d154); end
        n_tests++; if (rec_ovr_cnt !== 1) begin n_fail++; $display("FAIL ovr_count got %0d want 1", rec_ovr_cnt); end
        n_tests++; if (rec_ovr_edge !== 154) begin n_fail++; $display("FAIL ovr_edge got %0d want 154", rec_ovr_edge); end
        n_tests++; if (rec_ack_cnt !== 0) begin n_fail++; $display("FAIL ovr_no_ack got %0d want 0", rec_ack_cnt); end
        n_tests++; if (busy_hist[155] !== 1'b0) begin n_fail++; $display("FAIL ovr_idle got %b want 0", busy_hist[155]); end
        rif.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rif.rx_ready = 1'b0;
        n_tests++; if (rif.rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume got %b want 0", rif.rx_valid); end
        idle(4);
    endtask

    task automatic test_back_to_back;
        run_frame(8'h11, 1'b1, 0, 0, 190, -1, 1'b0, -1);
        n_tests++; if (rec_v154 !== 1'b1) begin n_fail++; $display("FAIL b2b_first got %b want 1", rec_v154); end
        idle(8);
        run_frame(8'h22, 1'b1, 0, 0, 190, 154, 1'b0, -1);
        n_tests++; if ({rec_v153, rec_v154} !== 2'b11) begin n_fail++; $display("FAIL b2b_valid got %b want 11", {rec_v153, rec_v154}); end
        n_tests++; if (rec_d154 !== 8'h22) begin n_fail++; $display("FAIL b2b_data got %h want 22", rec_d154); end
        n_tests++; if (rec_ovr_cnt !== 0) begin n_fail++; $display("FAIL b2b_no_ovr got %0d want 0", rec_ovr_cnt); end
        n_tests++; if (rec_ack_cnt !== 16) begin n_fail++; $display("FAIL b2b_ack got %0d want 16", rec_ack_cnt); end
        n_tests++; if ({rif.rx_valid, rif.rx_data} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL b2b_hold got %b/%h want 1/22", rif.rx_valid, rif.rx_data); end
        rif.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rif.rx_ready = 1'b0;
        idle(4);
    endtask

    task automatic test_reset_mid;
        run_frame(8'h77, 1'b1, 0, 0, 190, -1, 1'b1, 50);
        n_tests++; if (rst_busy_pre !== 1'b1) begin n_fail++; $display("FAIL rdata_pre_busy got %b want 1", rst_busy_pre); end
        n_tests++; if ({rst_busy, rst_valid, rst_ack} !== 3'b000) begin n_fail++; $display("FAIL rdata_clear got %b want 000", {rst_busy, rst_valid, rst_ack}); end
        idle(6);
        run_frame(8'h99, 1'b1, 0, 0, 190, -1, 1'b0, 170);
        n_tests++; if (rst_ack_pre !== 1'b1) begin n_fail++; $display("FAIL rack_pre_ack got %b want 1", rst_ack_pre); end
        n_tests++; if (rst_ack !== 1'b0) begin n_fail++; $display("FAIL rack_ack got %b want 0", rst_ack); end
        n_tests++; if (rst_line !== 1'b1) begin n_fail++; $display("FAIL rack_line got %b want 1", rst_line); end
        n_tests++; if ({rst_valid, rst_data} !== 9'h000) begin n_fail++; $display("FAIL rack_data got %b/%h want 0/00", rst_valid, rst_data); end
        n_tests++; if ({rst_busy, rst_ferr, rst_ovr} !== 3'b000) begin n_fail++; $display("FAIL rack_flags got %b want 000", {rst_busy, rst_ferr, rst_ovr}); end
        idle(6);
        run_frame(8'h5A, 1'b1, 0, 0, 190, -1, 1'b1, -1);
        n_tests++; if ({rec_v154, rec_d154} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL after_rst_data got %b/%h want 1/5a", rec_v154, rec_d154); end
        n_tests++; if (rec_ack_cnt !== 16 || rec_ack_first !== 162) begin n_fail++; $display("FAIL after_rst_ack got %0d@%0d want 16@162", rec_ack_cnt, rec_ack_first); end
        idle(4);
    endtask

    initial begin
        rif.rx_ready = 1'b0;
        test_reset();
        test_basic_a5();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
